seg_scan_decoder: RTL

Receive-side counterpart to the processor's multiplexed seven-segment display output. The block samples the scanned segment bus (SEG) and anode strobes (AN), and filters out scan transitions and ghosting. It decodes each stable digit pattern back to a hex nibble and assembles the four digits into a frame. On-chip self-check logic and host readback over the Tiny Tapeout pins use it to recover the displayed value without a physical display.

---
 rtl/seg_scan_decoder_if.sv | 19 +
 rtl/seg_scan_decoder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder_if.sv
// Bundles the scanned display bus and the recovered frame outputs.
// The display driver (master) drives SEG/AN; the decoder (slave) returns the decoded frame.
interface seg_scan_decoder_if;
    localparam int unsigned SEG_W = 8;
    localparam int unsigned AN_W  = 4;
    localparam int unsigned DIG_W = 16;
    localparam int unsigned CNT_W = 8;

    logic [SEG_W-1:0] SEG;
    logic [AN_W-1:0]  AN;
    logic [DIG_W-1:0] DIGITS;
    logic [AN_W-1:0]  DP;
    logic             VALID;
    logic             ERR;
    logic [CNT_W-1:0] FRAME_CNT;

    modport master (output SEG, AN, input DIGITS, DP, VALID, ERR, FRAME_CNT);
    modport slave  (input SEG, AN, output DIGITS, DP, VALID, ERR, FRAME_CNT);
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers the hex value shown on a multiplexed 7-segment display from its SEG/AN scan.
// Stable digits are decoded into shadow registers; a full seen mask publishes a frame.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input logic               CLK,
    input logic               BTN,
    seg_scan_decoder_if.slave bus
);
    localparam int unsigned SEG_W = 8;
    localparam int unsigned AN_W  = 4;
    localparam int unsigned DIG_W = 16;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    // Pattern-to-nibble table; bit 4 flags a decodable pattern.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = {1'b1, 4'h0};
            7'h06:   decode = {1'b1, 4'h1};
            7'h5B:   decode = {1'b1, 4'h2};
            7'h4F:   decode = {1'b1, 4'h3};
            7'h66:   decode = {1'b1, 4'h4};
            7'h6D:   decode = {1'b1, 4'h5};
            7'h7D:   decode = {1'b1, 4'h6};
            7'h07:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h6F:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h7C:   decode = {1'b1, 4'hB};
            7'h39:   decode = {1'b1, 4'hC};
            7'h5E:   decode = {1'b1, 4'hD};
            7'h79:   decode = {1'b1, 4'hE};
            7'h71:   decode = {1'b1, 4'hF};
            default: decode = 5'b0;
        endcase
    endfunction

    logic [SEG_W-1:0] seg_q;
    logic [AN_W-1:0]  an_q;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [AN_W-1:0]  seen_q, seen_d;
    logic [DIG_W-1:0] shadow_q, shadow_d;
    logic [AN_W-1:0]  shadow_dp_q, shadow_dp_d;
    logic [DIG_W-1:0] digits_q, digits_d;
    logic [AN_W-1:0]  dp_q, dp_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] frame_q, frame_d;

    logic [SEG_W-1:0] seg_c, prev_seg_c;
    logic [AN_W-1:0]  an_c, prev_an_c;
    logic             eligible_c, same_c, capture_c;
    logic [4:0]       dec_c;

    // The incoming sample is compared against the one held in the sample registers.
    assign seg_c      = SEG_ACTIVE_LOW ? ~bus.SEG : bus.SEG;
    assign an_c       = AN_ACTIVE_LOW  ? ~bus.AN  : bus.AN;
    assign prev_seg_c = SEG_ACTIVE_LOW ? ~seg_q   : seg_q;
    assign prev_an_c  = AN_ACTIVE_LOW  ? ~an_q    : an_q;
    assign eligible_c = (an_c != '0) && ((an_c & (an_c - AN_W'(1))) == '0);
    assign same_c     = (seg_c == prev_seg_c) && (an_c == prev_an_c);
    assign dec_c      = decode(seg_c[6:0]);

    // Dwell tracking, digit capture and frame assembly.
    always_comb begin
        dwell_d     = dwell_q;
        seen_d      = seen_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        digits_d    = digits_q;
        dp_d        = dp_q;
        valid_d     = 1'b0;
        err_d       = err_q;
        frame_d     = frame_q;
        capture_c   = 1'b0;

        if (!eligible_c) begin
            dwell_d = '0;
        end else if (same_c) begin
            dwell_d = (dwell_q == STABLE) ? dwell_q : dwell_q + CNT_W'(1);
        end else begin
            dwell_d = CNT_W'(1);
        end

        // Only the edge that reaches the threshold captures; saturation blocks repeats.
        capture_c = eligible_c && (dwell_d == STABLE) && (dwell_q != STABLE);

        if (capture_c) begin
            for (int i = 0; i < int'(AN_W); i++) begin
                if (an_c[i]) begin
                    seen_d[i] = 1'b1;
                    if (dec_c[4]) begin
                        shadow_d[4*i +: 4] = dec_c[3:0];
                        shadow_dp_d[i]     = seg_c[7];
                    end
                end
            end
            if (!dec_c[4]) begin
                err_d = 1'b1;
            end
            if (seen_d == '1) begin
                digits_d = shadow_d;
                dp_d     = shadow_dp_d;
                valid_d  = 1'b1;
                frame_d  = frame_q + CNT_W'(1);
                seen_d   = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (BTN) begin
            seg_q       <= '0;
            an_q        <= '0;
            dwell_q     <= '0;
            seen_q      <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            digits_q    <= '0;
            dp_q        <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_q     <= '0;
        end else begin
            seg_q       <= bus.SEG;
            an_q        <= bus.AN;
            dwell_q     <= dwell_d;
            seen_q      <= seen_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            digits_q    <= digits_d;
            dp_q        <= dp_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.DIGITS    = digits_q;
    assign bus.DP        = dp_q;
    assign bus.VALID     = valid_q;
    assign bus.ERR       = err_q;
    assign bus.FRAME_CNT = frame_q;
endmodule
